// File: rtl/max6675_sample_scheduler.sv
// Read scheduler for a MAX6675 frame engine: paces reads against the conversion time,
// validates frames, and publishes temperature plus a moving average with fault flags.
module max6675_sample_scheduler #(
  parameter int unsigned CONV_CYCLES    = 12_500_000,
  parameter int unsigned PERIOD_CYCLES  = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req,
  output logic        frame_start,
  input  logic        frame_busy,
  input  logic        frame_done,
  input  logic [15:0] frame_data,
  output logic [11:0] temperature,
  output logic [11:0] temp_avg,
  output logic        data_valid,
  output logic        fault_open,
  output logic        fault_timeout
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned TW    = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned WW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW    = 12 + AVG_LOG2;
  localparam int unsigned PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TW-1:0] PERIOD_T = TW'(PERIOD_CYCLES);
  localparam logic [TW-1:0] CONV_T   = TW'(CONV_CYCLES);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_CONV = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;
  localparam logic [2:0] PUBLISH   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          req_q, req_d;
  logic [12:0]   data_q, data_d;  // frame_data[14:2]: temperature and open-TC bit
  logic [11:0]   temp_q, temp_d;
  logic          open_q, open_d;
  logic          tmo_q, tmo_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          filled_q, filled_d;
  logic [11:0]   win_q [DEPTH];
  logic          push;
  logic [11:0]   temp_new;
  logic [SW-1:0] avg_full;
  logic          unused_bits;

  assign unused_bits = ^{frame_data[15], frame_data[1:0]};
  assign temp_new    = data_q[12:1];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    wd_d        = wd_q;
    req_d       = req_q | req;
    data_d      = data_q;
    temp_d      = temp_q;
    open_d      = open_q;
    tmo_d       = tmo_q;
    push        = 1'b0;
    frame_start = 1'b0;
    data_valid  = 1'b0;

    if (state_q != WAIT_DONE && timer_q != PERIOD_T) begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (enable || req_q) state_d = WAIT_CONV;
      end
      WAIT_CONV: begin
        if ((enable && timer_q >= PERIOD_T) || (req_q && timer_q >= CONV_T)) begin
          state_d = START;
        end else if (!enable && !req_q) begin
          state_d = IDLE;
        end
      end
      START: begin
        wd_d = '0;
        if (!frame_busy) begin
          frame_start = 1'b1;
          state_d     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // frame_done takes priority over a watchdog expiry in the same cycle
        if (frame_done) begin
          data_d  = frame_data[14:2];
          timer_d = '0;
          state_d = CHECK;
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          timer_d = '0;
          req_d   = req;
          state_d = WAIT_CONV;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      CHECK: begin
        req_d = req;
        if (data_q[0]) begin
          open_d  = 1'b1;
          state_d = WAIT_CONV;
        end else begin
          open_d  = 1'b0;
          tmo_d   = 1'b0;
          temp_d  = temp_new;
          push    = 1'b1;
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        data_valid = 1'b1;
        state_d    = WAIT_CONV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d    = sum_q;
    ptr_d    = ptr_q;
    filled_d = filled_q;
    if (push) begin
      if (!filled_q) begin
        sum_d    = SW'(temp_new) << AVG_LOG2;
        ptr_d    = '0;
        filled_d = 1'b1;
      end else begin
        sum_d = sum_q - SW'(win_q[ptr_q]) + SW'(temp_new);
        ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      wd_q     <= '0;
      req_q    <= 1'b0;
      data_q   <= '0;
      temp_q   <= '0;
      open_q   <= 1'b0;
      tmo_q    <= 1'b0;
      sum_q    <= '0;
      ptr_q    <= '0;
      filled_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wd_q     <= wd_d;
      req_q    <= req_d;
      data_q   <= data_d;
      temp_q   <= temp_d;
      open_q   <= open_d;
      tmo_q    <= tmo_d;
      sum_q    <= sum_d;
      ptr_q    <= ptr_d;
      filled_q <= filled_d;
      if (push) begin
        // the first sample after reset seeds every slot so the average starts at it
        if (!filled_q) begin
          for (int i = 0; i < DEPTH; i++) win_q[i] <= temp_new;
        end else begin
          win_q[ptr_q] <= temp_new;
        end
      end
    end
  end

  assign avg_full      = sum_q >> AVG_LOG2;
  assign temp_avg      = avg_full[11:0];
  assign temperature   = temp_q;
  assign fault_open    = open_q;
  assign fault_timeout = tmo_q;

endmodule
